// File: rtl/wav_rom_sched.sv
// wav_rom_sched: multi-channel sample playback scheduler.
// Paces per-channel ROM fetches, arbitrates the single ROM read port
// round-robin, captures returned bytes as per-channel samples and
// produces a registered unsigned mix. A ROM download idles every channel.
module wav_rom_sched #(
  parameter int NCH  = 4,
  parameter int AW   = 16,
  parameter int DIVW = 12,
  localparam int CW  = $clog2(NCH),
  localparam int MW  = 8 + CW
) (
  input  logic                 clk_sys_i,
  input  logic                 reset_n_i,
  input  logic                 load_busy_i,
  input  logic [NCH-1:0]       trig_i,
  input  logic [NCH-1:0]       stop_i,
  input  logic [NCH*AW-1:0]    start_addr_i,
  input  logic [NCH*AW-1:0]    len_i,
  input  logic [NCH*DIVW-1:0]  div_i,
  output logic [AW-1:0]        rom_a_o,
  output logic                 rom_rd_o,
  input  logic [7:0]           rom_d_i,
  output logic [NCH-1:0]       ch_play_o,
  output logic [NCH*8-1:0]     ch_sample_o,
  output logic [MW-1:0]        mix_o,
  output logic [NCH-1:0]       overrun_o
);

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } chan_state_e;

  // Per-channel playback state
  chan_state_e     state_q   [NCH];
  chan_state_e     state_d   [NCH];
  logic [AW-1:0]   ptr_q     [NCH];
  logic [AW-1:0]   ptr_d     [NCH];
  logic [AW-1:0]   rem_q     [NCH];
  logic [AW-1:0]   rem_d     [NCH];
  logic [DIVW-1:0] period_q  [NCH];
  logic [DIVW-1:0] period_d  [NCH];
  logic [DIVW-1:0] presc_q   [NCH];
  logic [DIVW-1:0] presc_d   [NCH];
  logic [7:0]      sample_q  [NCH];
  logic [7:0]      sample_d  [NCH];
  logic [NCH-1:0]  pending_q, pending_d;
  logic [NCH-1:0]  overrun_q, overrun_d;

  // Fetch pipeline: issue stage (rom_a/rom_rd) and data-return stage
  logic [CW-1:0]   rr_q, rr_d;
  logic [AW-1:0]   rom_a_q, rom_a_d;
  logic            rom_rd_q, rom_rd_d;
  logic [CW-1:0]   tag_q, tag_d;
  logic            ret_valid_q, ret_valid_d;
  logic [CW-1:0]   ret_tag_q, ret_tag_d;
  logic [MW-1:0]   mix_q, mix_d;

  // Per-cycle channel events
  logic [NCH-1:0]  start_c, abort_c, ret_hit_c, done_c, flush_c;
  logic [NCH-1:0]  expire_c, eligible_c, grant_c;
  logic            grant_any;
  logic [CW-1:0]   grant_idx;
  logic [CW-1:0]   scan_idx;

  // Decode triggers, stops, lockout and returning data into per-channel events;
  // a flushed channel may neither be granted nor accept in-flight data
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      start_c[k]    = ~load_busy_i & ~stop_i[k] & trig_i[k] &
                      (len_i[k*AW +: AW] != '0);
      abort_c[k]    = load_busy_i | stop_i[k] | (start_c[k] & (state_q[k] == PLAY));
      ret_hit_c[k]  = ret_valid_q & (ret_tag_q == CW'(k)) &
                      (state_q[k] == PLAY) & ~abort_c[k];
      done_c[k]     = ret_hit_c[k] & (rem_q[k] == AW'(1));
      flush_c[k]    = abort_c[k] | done_c[k] | start_c[k];
      expire_c[k]   = (state_q[k] == PLAY) & (presc_q[k] == period_q[k]);
      eligible_c[k] = pending_q[k] & ~flush_c[k] & (state_q[k] == PLAY);
    end
  end

  // Round-robin arbiter: first eligible channel at or after the RR pointer
  always_comb begin
    grant_any = 1'b0;
    grant_idx = rr_q;
    scan_idx  = rr_q;
    grant_c   = '0;
    for (int i = 0; i < NCH; i++) begin
      scan_idx = rr_q + CW'(i);
      if (!grant_any && eligible_c[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx;
      end
    end
    if (grant_any) begin
      grant_c[grant_idx] = 1'b1;
    end
  end

  // Issue and return stage next-state; returns for flushed channels are dropped
  always_comb begin
    rom_rd_d    = grant_any;
    rom_a_d     = grant_any ? ptr_q[grant_idx] : rom_a_q;
    tag_d       = grant_any ? grant_idx : tag_q;
    rr_d        = grant_any ? grant_idx + CW'(1) : rr_q;
    ret_valid_d = rom_rd_q & ~flush_c[tag_q];
    ret_tag_d   = tag_q;
  end

  // Channel next-state: prescaler pacing, sample capture, start and stop
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      state_d[k]   = state_q[k];
      ptr_d[k]     = ptr_q[k];
      rem_d[k]     = rem_q[k];
      period_d[k]  = period_q[k];
      presc_d[k]   = presc_q[k];
      sample_d[k]  = sample_q[k];
      pending_d[k] = pending_q[k];
      overrun_d[k] = overrun_q[k];

      if (state_q[k] == PLAY) begin
        presc_d[k]   = expire_c[k] ? '0 : presc_q[k] + DIVW'(1);
        pending_d[k] = (pending_q[k] & ~grant_c[k]) | expire_c[k];
        overrun_d[k] = overrun_q[k] | (expire_c[k] & pending_q[k] & ~grant_c[k]);
      end else begin
        sample_d[k]  = 8'h80;
      end

      if (ret_hit_c[k]) begin
        sample_d[k] = rom_d_i;
        ptr_d[k]    = ptr_q[k] + AW'(1);
        rem_d[k]    = rem_q[k] - AW'(1);
      end

      if (start_c[k]) begin
        state_d[k]   = PLAY;
        ptr_d[k]     = start_addr_i[k*AW +: AW];
        rem_d[k]     = len_i[k*AW +: AW];
        period_d[k]  = div_i[k*DIVW +: DIVW];
        presc_d[k]   = '0;
        pending_d[k] = 1'b0;
        overrun_d[k] = 1'b0;
      end else if (load_busy_i || stop_i[k] || done_c[k]) begin
        state_d[k]   = IDLE;
        presc_d[k]   = '0;
        pending_d[k] = 1'b0;
      end
    end
  end

  // Mix is the plain unsigned sum of the current channel samples
  always_comb begin
    mix_d = '0;
    for (int k = 0; k < NCH; k++) begin
      mix_d = mix_d + MW'(sample_q[k]);
    end
  end

  // State registers; every register clears immediately on reset assertion
  always_ff @(posedge clk_sys_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int k = 0; k < NCH; k++) begin
        state_q[k]  <= IDLE;
        ptr_q[k]    <= '0;
        rem_q[k]    <= '0;
        period_q[k] <= '0;
        presc_q[k]  <= '0;
        sample_q[k] <= 8'h80;
      end
      pending_q   <= '0;
      overrun_q   <= '0;
      rr_q        <= '0;
      rom_a_q     <= '0;
      rom_rd_q    <= 1'b0;
      tag_q       <= '0;
      ret_valid_q <= 1'b0;
      ret_tag_q   <= '0;
      mix_q       <= MW'(NCH * 128);
    end else begin
      for (int k = 0; k < NCH; k++) begin
        state_q[k]  <= state_d[k];
        ptr_q[k]    <= ptr_d[k];
        rem_q[k]    <= rem_d[k];
        period_q[k] <= period_d[k];
        presc_q[k]  <= presc_d[k];
        sample_q[k] <= sample_d[k];
      end
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      rr_q        <= rr_d;
      rom_a_q     <= rom_a_d;
      rom_rd_q    <= rom_rd_d;
      tag_q       <= tag_d;
      ret_valid_q <= ret_valid_d;
      ret_tag_q   <= ret_tag_d;
      mix_q       <= mix_d;
    end
  end

  // Flatten per-channel state onto the output ports
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      ch_play_o[k]          = (state_q[k] == PLAY);
      ch_sample_o[k*8 +: 8] = sample_q[k];
    end
    overrun_o = overrun_q;
    rom_a_o   = rom_a_q;
    rom_rd_o  = rom_rd_q;
    mix_o     = mix_q;
  end

endmodule
